// File: rtl/peak_window_reader.sv
// Reduces a framed, signed sample stream to one peak event per window.
// Each event reports the peak value, the peak's offset and the window length, then holds off for REFRACTORY samples.
//   state   | meaning
//   IDLE    | waiting for a rising edge on i_signal_valid
//   SEARCH  | inside a window, tracking the maximum sample and its offset
//   REFRACT | hold-off after a reported peak; framing is ignored
module peak_window_reader #(
  parameter int DATA_WIDTH = 11,
  parameter int IDX_WIDTH  = 16,
  parameter int REFRACTORY = 72
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_ce,
  input  logic signed [DATA_WIDTH-1:0] i_signal,
  input  logic                         i_signal_valid,
  input  logic signed [DATA_WIDTH-1:0] i_threshold,
  output logic signed [DATA_WIDTH-1:0] o_peak_value,
  output logic        [IDX_WIDTH-1:0]  o_peak_index,
  output logic        [IDX_WIDTH-1:0]  o_peak_len,
  output logic                         o_peak_valid,
  output logic                         o_peak_drop,
  output logic                         o_busy
);

  typedef enum logic [1:0] {IDLE, SEARCH, REFRACT} state_t;

  localparam int RW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
  localparam logic [IDX_WIDTH-1:0] IDX_MAX = '1;

  state_t                       state_q, state_d;
  logic                         prev_valid;
  logic signed [DATA_WIDTH-1:0] max_q;
  logic        [IDX_WIDTH-1:0]  idx_q, len_q;
  logic        [RW-1:0]         refr_q;
  logic                         start, grow, fire, drop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    grow    = 1'b0;
    fire    = 1'b0;
    drop    = 1'b0;
    if (i_ce) begin
      case (state_q)
        IDLE: begin
          if (i_signal_valid && !prev_valid) begin
            start   = 1'b1;
            state_d = SEARCH;
          end
        end
        SEARCH: begin
          if (i_signal_valid) begin
            grow = 1'b1;
          end else if (max_q >= i_threshold) begin
            fire    = 1'b1;
            state_d = (REFRACTORY > 0) ? REFRACT : IDLE;
          end else begin
            drop    = 1'b1;
            state_d = IDLE;
          end
        end
        REFRACT: begin
          if (refr_q == RW'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_valid   <= 1'b0;
      max_q        <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      refr_q       <= '0;
      o_peak_value <= '0;
      o_peak_index <= '0;
      o_peak_len   <= '0;
      o_peak_valid <= 1'b0;
      o_peak_drop  <= 1'b0;
    end else begin
      o_peak_valid <= fire;
      o_peak_drop  <= drop;
      // prev_valid keeps tracking in every state so REFRACT can mask a held-high window
      if (i_ce) prev_valid <= i_signal_valid;
      if (start) begin
        max_q <= i_signal;
        idx_q <= '0;
        len_q <= IDX_WIDTH'(1);
      end
      if (grow) begin
        if (len_q != IDX_MAX) len_q <= len_q + IDX_WIDTH'(1);
        if (i_signal > max_q) begin
          max_q <= i_signal;
          idx_q <= len_q;
        end
      end
      if (fire || drop) begin
        o_peak_value <= max_q;
        o_peak_index <= idx_q;
        o_peak_len   <= len_q;
      end
      if (fire)                               refr_q <= RW'(REFRACTORY);
      else if (i_ce && state_q == REFRACT)    refr_q <= refr_q - RW'(1);
    end
  end

  assign o_busy = (state_q == REFRACT);

endmodule

// File: tb/tb_peak_window_reader.sv
// Randomized and directed bench for peak_window_reader at three hold-off lengths.
// A window-level reference model feeds an event scoreboard drained by a monitor.
module tb_peak_window_reader;

  localparam int NDUT = 3;
  localparam int RV [NDUT] = '{72, 4, 0};
  localparam int SAT = 65535;

  typedef struct {
    bit hit;
    int val;
    int idx;
    int len;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic vld = 1'b0;
  logic signed [10:0] sig = '0;
  logic signed [10:0] thr = '0;

  logic signed [10:0] pv [NDUT];
  logic [15:0] pi [NDUT];
  logic [15:0] pl [NDUT];
  logic pvld [NDUT];
  logic pdrp [NDUT];
  logic pbusy [NDUT];

  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    peak_window_reader #(
      .DATA_WIDTH(11),
      .IDX_WIDTH(16),
      .REFRACTORY(RV[g])
    ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_ce(ce),
      .i_signal(sig),
      .i_signal_valid(vld),
      .i_threshold(thr),
      .o_peak_value(pv[g]),
      .o_peak_index(pi[g]),
      .o_peak_len(pl[g]),
      .o_peak_valid(pvld[g]),
      .o_peak_drop(pdrp[g]),
      .o_busy(pbusy[g])
    );
  end

  // Reference model: 0 waiting, 1 collecting a window, 2 holding off
  int   mst [NDUT];
  bit   mprev [NDUT];
  int   mcnt [NDUT];
  int   win [NDUT][$];
  int   ev_val [NDUT];
  int   ev_idx [NDUT];
  int   ev_len [NDUT];
  ev_t  sb [NDUT][$];

  task automatic chk(input string nm, input int k, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d (REFRACTORY=%0d) t=%0t: got %0d expected %0d", nm, k, RV[k], $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < NDUT; k++) begin
      if (rst) begin
        mst[k] = 0; mprev[k] = 0; mcnt[k] = 0;
        win[k].delete();
        sb[k].delete();
        ev_val[k] = 0; ev_idx[k] = 0; ev_len[k] = 0;
      end else if (ce) begin
        if (mst[k] == 0) begin
          if (vld && !mprev[k]) begin
            win[k].delete();
            win[k].push_back(int'(sig));
            mst[k] = 1;
          end
        end else if (mst[k] == 1) begin
          if (vld) begin
            win[k].push_back(int'(sig));
          end else begin
            int m, mi;
            ev_t e;
            m = win[k][0]; mi = 0;
            for (int i = 1; i < win[k].size(); i++)
              if (win[k][i] > m) begin m = win[k][i]; mi = i; end
            ev_val[k] = m;
            ev_idx[k] = (mi > SAT) ? SAT : mi;
            ev_len[k] = (win[k].size() > SAT) ? SAT : win[k].size();
            e.hit = (m >= int'(thr));
            e.val = ev_val[k]; e.idx = ev_idx[k]; e.len = ev_len[k];
            sb[k].push_back(e);
            if (e.hit && RV[k] > 0) begin
              mst[k] = 2; mcnt[k] = RV[k];
            end else begin
              mst[k] = 0;
            end
          end
        end else begin
          mcnt[k]--;
          if (mcnt[k] == 0) mst[k] = 0;
        end
        mprev[k] = vld;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NDUT; k++) begin
        bit pulse;
        ev_t e;
        pulse = pvld[k] | pdrp[k];
        chk("pulse_exclusive", k, int'(pvld[k] & pdrp[k]), 0);
        chk("pulse_present", k, int'(pulse), int'(sb[k].size() > 0));
        if (pulse && sb[k].size() > 0) begin
          e = sb[k].pop_front();
          chk("pulse_kind_valid", k, int'(pvld[k]), int'(e.hit));
          chk("event_value", k, int'(pv[k]), e.val);
          chk("event_index", k, int'(pi[k]), e.idx);
          chk("event_len", k, int'(pl[k]), e.len);
        end else if (sb[k].size() > 0) begin
          void'(sb[k].pop_front());
        end
        chk("busy", k, int'(pbusy[k]), int'(mst[k] == 2));
        chk("held_value", k, int'(pv[k]), ev_val[k]);
        chk("held_index", k, int'(pi[k]), ev_idx[k]);
        chk("held_len", k, int'(pl[k]), ev_len[k]);
      end
    end
  end

  task automatic step(input bit c, input bit v, input int s);
    @(negedge clk);
    ce = c; vld = v; sig = 11'(s);
  endtask

  task automatic feed(input int q[$]);
    foreach (q[i]) step(1'b1, 1'b1, q[i]);
    step(1'b1, 1'b0, int'($urandom));
  endtask

  task automatic rest(input int n);
    repeat (n) step(1'b1, 1'b0, int'($urandom));
  endtask

  task automatic chk_all_zero(input string nm);
    for (int k = 0; k < NDUT; k++) begin
      chk({nm, "_value"}, k, int'(pv[k]), 0);
      chk({nm, "_index"}, k, int'(pi[k]), 0);
      chk({nm, "_len"}, k, int'(pl[k]), 0);
      chk({nm, "_pulse"}, k, int'(pvld[k] | pdrp[k]), 0);
      chk({nm, "_busy"}, k, int'(pbusy[k]), 0);
    end
  endtask

  initial begin
    int q[$];
    #12;
    chk_all_zero("reset");
    #11 rst = 1'b0;

    thr = 4;
    q = '{3, 9, 5, -2}; feed(q); rest(80);

    thr = 0;
    q = '{-5, -1, -3}; feed(q); rest(3);

    q = '{7, 7, 2}; feed(q); rest(80);

    thr = 50;
    q = '{100}; feed(q); rest(80);

    thr = 0;
    q = '{5}; feed(q);
    step(1'b1, 1'b0, 0);
    repeat (80) step(1'b1, 1'b1, int'($urandom));
    step(1'b1, 1'b0, 0);
    q = '{1, 2}; feed(q); rest(80);

    thr = 4;
    q = '{3, 9, 5, -2};
    foreach (q[i]) begin
      step(1'b1, 1'b1, q[i]);
      step(1'b0, 1'($urandom), int'($urandom));
    end
    step(1'b1, 1'b0, 0);
    repeat (80) begin
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'($urandom), int'($urandom));
    end

    thr = 0;
    step(1'b1, 1'b1, 20);
    step(1'b1, 1'b1, 30);
    @(negedge clk);
    #2 rst = 1'b1; ce = 1'b0; vld = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    #2 rst = 1'b0;
    q = '{-7, 4}; feed(q); rest(80);

    repeat (3000) begin
      step(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 5) != 0) ? vld : ~vld, int'($urandom));
      if ($urandom_range(0, 40) == 0) thr = 11'($urandom_range(0, 300)) - 11'sd150;
    end
    rest(80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
